// File: rtl/downcounter.sv
// Synchronous N-bit down counter with parallel load, zero decode and registered borrow pulse.
// Optional macro DOWNCOUNTER_AUTORELOAD_EN adds a reload register used as the underflow value.
module downcounter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         zero,
  output logic         borrow
);

  logic [N-1:0] wrap_val;

`ifdef DOWNCOUNTER_AUTORELOAD_EN
  logic [N-1:0] reload;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reload <= '0;
    end else if (load) begin
      reload <= d;
    end
  end

  assign wrap_val = reload;
`else
  assign wrap_val = '1;
`endif

  // Priority: reset, load, enable, hold; borrow is high only after an underflowing edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q      <= '0;
      borrow <= 1'b0;
    end else if (load) begin
      q      <= d;
      borrow <= 1'b0;
    end else if (en) begin
      if (q == '0) begin
        q      <= wrap_val;
        borrow <= 1'b1;
      end else begin
        q      <= q - 1'b1;
        borrow <= 1'b0;
      end
    end else begin
      borrow <= 1'b0;
    end
  end

  assign zero = (q == '0);

endmodule

// File: tb/tb_downcounter.sv
// Directed self-checking bench for downcounter (N=4); expectations adapt to DOWNCOUNTER_AUTORELOAD_EN.
module tb_downcounter;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [N-1:0] d;
  logic [N-1:0] q;
  logic         zero;
  logic         borrow;

  int errors = 0;
  int checks = 0;

  downcounter #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .load   (load),
    .d      (d),
    .q      (q),
    .zero   (zero),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef DOWNCOUNTER_AUTORELOAD_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  initial begin
    int pulses;
    int last_pulse;
    int gap_bad;
    int en_pat[6];
    int q_exp[6];

    en_pat = '{1, 0, 0, 1, 0, 1};
    q_exp  = '{6, 6, 6, 5, 5, 4};

    rst_n = 1'b0; en = 1'b1; load = 1'b1; d = 4'd5;
    step();
    step();
    check("reset_q", q, 0);
    check("reset_zero", zero, 1);
    check("reset_borrow", borrow, 0);

    rst_n = 1'b1; en = 1'b0; load = 1'b0;
    step();
    check("hold_after_reset_q", q, 0);
    check("hold_after_reset_borrow", borrow, 0);

    // Load 3 then count down through underflow.
    load = 1'b1; d = 4'd3;
    step();
    check("load3_q", q, 3);
    check("load3_zero", zero, 0);
    load = 1'b0; en = 1'b1;
    step();
    check("cnt_q2", q, 2);
    check("cnt_b2", borrow, 0);
    step();
    check("cnt_q1", q, 1);
    step();
    check("cnt_q0", q, 0);
    check("cnt_zero0", zero, 1);
    check("cnt_b0", borrow, 0);
    step();
    check("underflow_q", q, AUTO ? 3 : 15);
    check("underflow_borrow", borrow, 1);
    check("underflow_zero", zero, 0);
    en = 1'b0;
    step();
    check("post_underflow_borrow", borrow, 0);
    check("post_underflow_hold_q", q, AUTO ? 3 : 15);

    // Free run from 0 for 48 edges.
    load = 1'b1; d = 4'd0;
    step();
    load = 1'b0; en = 1'b1;
    pulses = 0; last_pulse = -1; gap_bad = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (borrow) begin
        if (!AUTO && last_pulse >= 0 && (i - last_pulse) != 16) gap_bad++;
        pulses++;
        last_pulse = i;
      end
    end
    check("freerun_pulses", pulses, AUTO ? 48 : 3);
    check("freerun_gap", gap_bad, 0);
    check("freerun_end_q", q, 0);

    // Load beats underflow with q==0.
    en = 1'b0; load = 1'b1; d = 4'd0;
    step();
    check("preload_zero_q", q, 0);
    en = 1'b1; load = 1'b1; d = 4'd9;
    step();
    check("load_beats_uf_q", q, 9);
    check("load_beats_uf_borrow", borrow, 0);

    // Mid-operation reset, then underflow from 0.
    load = 1'b1; d = 4'd5; en = 1'b0;
    step();
    check("load5_q", q, 5);
    load = 1'b0; en = 1'b1; rst_n = 1'b0;
    step();
    check("midreset_q", q, 0);
    check("midreset_borrow", borrow, 0);
    rst_n = 1'b1;
    step();
    check("uf_after_reset_q", q, AUTO ? 0 : 15);
    check("uf_after_reset_borrow", borrow, 1);
    // Reset during a borrow pulse kills it.
    rst_n = 1'b0;
    step();
    check("reset_in_pulse_borrow", borrow, 0);
    check("reset_in_pulse_q", q, 0);
    rst_n = 1'b1;

    // Enable gating.
    en = 1'b0; load = 1'b1; d = 4'd7;
    step();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = en_pat[i][0];
      step();
      check($sformatf("gate_q%0d", i), q, q_exp[i]);
      check($sformatf("gate_b%0d", i), borrow, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
